fetch_queue: RTL and testbench

Parametrised instruction-fetch queue that sits between the fetch PC and the IF/ID stage. Each cycle with free space it reads one word from an asynchronous-read instruction memory into a DEPTH-entry FIFO. It then presents whole instructions, either one word, or two words (instruction + immediate) when the extension bit is set, to the decoder over a valid/ready handshake. A redirect input flushes the queue for jumps and branches.

---
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- bundle of the fetch queue's memory, redirect and decode ports.
//   master : the fetch queue side (drives mem_addr/mem_req and the out_* stream).
//   slave  : the environment side (memory, branch unit and decoder).
// Signals:
//   mem_addr/mem_req/mem_rdata      : asynchronous-read instruction memory port
//   redirect/redirect_pc            : flush and restart fetch
//   out_valid/out_ready/out_instr/out_imedi/out_pc/out_bis : decoder handshake
//   count                           : queue occupancy
interface fetch_queue_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_req;
   logic [WIDTH-1:0]  mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_instr;
   logic [WIDTH-1:0]  out_imedi;
   logic [ADDR_W-1:0] out_pc;
   logic              out_bis;
   logic [CW-1:0]     count;

   modport master (
      output mem_addr, mem_req, out_valid, out_instr, out_imedi, out_pc, out_bis, count,
      input  mem_rdata, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  mem_addr, mem_req, out_valid, out_instr, out_imedi, out_pc, out_bis, count,
      output mem_rdata, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction-fetch queue between the fetch PC and IF/ID.
// Each cycle with free space one word is read from an async-read memory into a
// DEPTH-entry FIFO of {addr, word}. The head is presented as a one-word or a
// two-word (instruction + immediate, flagged by word[EXT_BIT]) instruction over
// a valid/ready handshake. redirect flushes the queue and restarts fetch.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fetch_queue_if.master (memory port, redirect, decode stream, count)
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present a single-word
// instruction straight from mem_rdata when the queue is empty.
module fetch_queue #(
   parameter int WIDTH   = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 4,
   parameter int EXT_BIT = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   // entry storage carries no reset; occupancy alone says what is live
   logic [WIDTH-1:0]  word_mem [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];

   logic [PW-1:0]     rd_ptr_p1;
   logic              h0_bis;
   logic              q_valid;
   logic              mem_req;
   logic              byp_pres;
   logic              byp_take;
   logic              push;
   logic              pop;
   logic [CW-1:0]     popn;

   always_comb begin
      rd_ptr_p1 = rd_ptr_q + PW'(1);
      h0_bis    = word_mem[rd_ptr_q][EXT_BIT];
      mem_req   = (count_q < CW'(DEPTH)) && !bus.redirect;
      // a two-word head needs its immediate in the queue before it is valid
      q_valid   = !bus.redirect && (count_q != '0) && (!h0_bis || (count_q >= CW'(2)));

`ifdef FETCH_QUEUE_BYPASS_EN
      byp_pres  = (count_q == '0) && mem_req && !bus.mem_rdata[EXT_BIT];
`else
      byp_pres  = 1'b0;
`endif

      byp_take  = byp_pres && bus.out_ready;
      // a bypassed word that is consumed is not also written into the queue
      push      = mem_req && !byp_take;
      pop       = q_valid && bus.out_ready;
      popn      = '0;
      if (pop) popn = h0_bis ? CW'(2) : CW'(1);

      bus.mem_addr  = fetch_pc_q;
      bus.mem_req   = mem_req;
      bus.count     = count_q;
      bus.out_valid = 1'b0;
      bus.out_instr = '0;
      bus.out_imedi = '0;
      bus.out_pc    = '0;
      bus.out_bis   = 1'b0;
      if (q_valid) begin
         bus.out_valid = 1'b1;
         bus.out_instr = word_mem[rd_ptr_q];
         bus.out_pc    = addr_mem[rd_ptr_q];
         bus.out_bis   = h0_bis;
         if (h0_bis) bus.out_imedi = word_mem[rd_ptr_p1];
      end else if (byp_pres) begin
         bus.out_valid = 1'b1;
         bus.out_instr = bus.mem_rdata;
         bus.out_pc    = fetch_pc_q;
      end

      // pointer arithmetic wraps naturally since DEPTH is a power of two
      fetch_pc_d = mem_req ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + popn[PW-1:0];
      count_d    = count_q + CW'(push) - popn;
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         word_mem[wr_ptr_q] <= bus.mem_rdata;
         addr_mem[wr_ptr_q] <= fetch_pc_q;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed test of fetch_queue (default build, no bypass).
// A 64K-word memory model answers mem_addr combinationally; untouched words
// hold {1'b0, addr[14:0]} so they are single-word and easy to predict.
module tb_fetch_queue;
   logic clk;
   logic reset_n;
   int   n_assert;
   int   n_fail;

   logic [15:0] imem [0:65535];

   fetch_queue_if #(.WIDTH(16), .ADDR_W(16), .DEPTH(4)) bus ();

   fetch_queue #(.WIDTH(16), .ADDR_W(16), .DEPTH(4), .EXT_BIT(15)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.mem_rdata = imem[bus.mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle just after it
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      for (int i = 0; i < 65536; i++) imem[i] = {1'b0, 15'(i)};
      imem[0] = 16'hA120;
      imem[1] = 16'h007B;
      imem[2] = 16'h4331;
      reset_n         = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = 1'b1;
      tick;
      tick;

      // reset state
      chk("rst_count",    32'(bus.count),     32'd0);
      chk("rst_valid",    32'(bus.out_valid), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr),  32'h0);
      chk("rst_mem_req",  32'(bus.mem_req),   32'd1);
      chk("rst_instr",    32'(bus.out_instr), 32'h0);
      chk("rst_pc",       32'(bus.out_pc),    32'h0);

      // two-word instruction followed by a single-word one
      reset_n = 1'b1;
      tick;
      chk("e1_count", 32'(bus.count),     32'd1);
      chk("e1_valid", 32'(bus.out_valid), 32'd0);
      tick;
      chk("e2_valid", 32'(bus.out_valid), 32'd1);
      chk("e2_instr", 32'(bus.out_instr), 32'hA120);
      chk("e2_imedi", 32'(bus.out_imedi), 32'h007B);
      chk("e2_pc",    32'(bus.out_pc),    32'h0);
      chk("e2_bis",   32'(bus.out_bis),   32'd1);
      tick;
      chk("e3_valid", 32'(bus.out_valid), 32'd1);
      chk("e3_instr", 32'(bus.out_instr), 32'h4331);
      chk("e3_imedi", 32'(bus.out_imedi), 32'h0);
      chk("e3_pc",    32'(bus.out_pc),    32'h2);
      chk("e3_bis",   32'(bus.out_bis),   32'd0);

      // fill with out_ready low, then drain in order
      imem[0] = 16'h0000;
      imem[1] = 16'h0001;
      imem[2] = 16'h0002;
      bus.out_ready = 1'b0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick;
         chk("fill_count", 32'(bus.count), 32'(k));
      end
      chk("full_mem_req",  32'(bus.mem_req),  32'd0);
      chk("full_mem_addr", 32'(bus.mem_addr), 32'h4);
      tick;
      chk("hold_count",    32'(bus.count),    32'd4);
      chk("hold_mem_addr", 32'(bus.mem_addr), 32'h4);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(bus.out_valid), 32'd1);
         chk("drain_pc",    32'(bus.out_pc),    32'(k));
         tick;
      end
      // full queue could not push on its first pop, so occupancy settles at 3
      chk("drain_count", 32'(bus.count), 32'd3);

      // redirect on a full queue with out_ready high
      bus.out_ready = 1'b0;
      tick;
      chk("refill_count", 32'(bus.count), 32'd4);
      bus.out_ready   = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0040;
      #1;
      chk("redir_valid_forced", 32'(bus.out_valid), 32'd0);
      chk("redir_mem_req",      32'(bus.mem_req),   32'd0);
      tick;
      bus.redirect = 1'b0;
      chk("redir_count",    32'(bus.count),     32'd0);
      chk("redir_valid",    32'(bus.out_valid), 32'd0);
      chk("redir_mem_addr", 32'(bus.mem_addr),  32'h0040);
      tick;
      chk("redir_first_valid", 32'(bus.out_valid), 32'd1);
      chk("redir_first_pc",    32'(bus.out_pc),    32'h0040);
      chk("redir_first_instr", 32'(bus.out_instr), 32'h0040);
      chk("redir_first_count", 32'(bus.count),     32'd1);

      // fetch address wrap from 0xFFFF to 0x0000
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      tick;
      bus.redirect = 1'b0;
      chk("wrap_mem_addr0", 32'(bus.mem_addr), 32'hFFFF);
      tick;
      chk("wrap_pc0",       32'(bus.out_pc),    32'hFFFF);
      chk("wrap_instr0",    32'(bus.out_instr), 32'h7FFF);
      chk("wrap_mem_addr1", 32'(bus.mem_addr),  32'h0000);
      tick;
      chk("wrap_pc1",    32'(bus.out_pc),    32'h0000);
      chk("wrap_instr1", 32'(bus.out_instr), 32'h0000);
      chk("wrap_count",  32'(bus.count),     32'd1);

      // two-word head stalls while only its first word is queued
      imem[16'h0083] = 16'h8000;
      imem[16'h0084] = 16'h1234;
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0083;
      tick;
      bus.redirect = 1'b0;
      tick;
      chk("stall_count", 32'(bus.count),     32'd1);
      chk("stall_valid", 32'(bus.out_valid), 32'd0);
      chk("stall_bis",   32'(bus.out_bis),   32'd0);
      tick;
      chk("late_count", 32'(bus.count),     32'd2);
      chk("late_valid", 32'(bus.out_valid), 32'd1);
      chk("late_instr", 32'(bus.out_instr), 32'h8000);
      chk("late_imedi", 32'(bus.out_imedi), 32'h1234);
      chk("late_pc",    32'(bus.out_pc),    32'h0083);
      chk("late_bis",   32'(bus.out_bis),   32'd1);
      bus.out_ready = 1'b1;
      tick;
      // two-word pop with a simultaneous push: 2 + 1 - 2
      chk("pop2_count", 32'(bus.count),     32'd1);
      chk("pop2_pc",    32'(bus.out_pc),    32'h0085);
      chk("pop2_instr", 32'(bus.out_instr), 32'h0085);

      // asynchronous reset mid-stream
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0010;
      tick;
      bus.redirect = 1'b0;
      tick;
      tick;
      tick;
      chk("pre_rst_count", 32'(bus.count), 32'd3);
      reset_n = 1'b0;
      #1;
      chk("arst_count",    32'(bus.count),     32'd0);
      chk("arst_valid",    32'(bus.out_valid), 32'd0);
      chk("arst_mem_addr", 32'(bus.mem_addr),  32'h0);
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      tick;
      chk("restart_valid", 32'(bus.out_valid), 32'd1);
      chk("restart_pc",    32'(bus.out_pc),    32'h0);
      chk("restart_instr", 32'(bus.out_instr), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
